instr_fetch_unit: RTL and testbench

Instruction fetch stage feeding the single-cycle `riscv` core's decode/control path. Holds the fetch PC, issues word reads to a synchronous instruction memory with 1-cycle read latency, and buffers returned instructions with their PCs in a small prefetch FIFO. Decode consumes them over a valid/ready handshake. Taken branches and `jal` from the datapath redirect the PC and squash all buffered and in-flight fetches.

---
 rtl/rv_fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 78 +++++++
 tb/tb_instr_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush beats push, push and pop may coincide.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       din,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic [OCC_W-1:0]   occ
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t             mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [OCC_W-1:0]         occ_q;
  logic                     do_pop;

  assign do_pop = pop & (occ_q != '0);
  assign head   = mem[rd_ptr];
  assign occ    = occ_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(do_pop);
    end
  end

  // NOTE: entry storage is never reset; occ gates whether the head is visible,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (flush)
    !(push && (occ_q == OCC_W'(DEPTH)) && !pop));
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, one outstanding imem read, credit-based request throttle
// and a prefetch FIFO drained by decode over valid/ready.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int          IMEM_ADDR_W = 9,
  parameter int          FIFO_DEPTH  = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [31:0]            if_instr,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_pc4
);

  localparam int             OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W:0] DEPTH_V = (OCC_W + 1)'(FIFO_DEPTH);

  logic [31:0]      fpc;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   used;
  logic             pop;
  logic             flush;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  assign if_valid = (occ != '0);
  assign pop      = if_valid & if_ready;

  // Slots committed after this edge; a pop frees its slot in the same cycle.
  assign used     = {1'b0, occ} + (OCC_W + 1)'(inflight) - (OCC_W + 1)'(pop);
  assign imem_req = ~reset & ~redirect_valid & (used < DEPTH_V);
  assign imem_addr = fpc[IMEM_ADDR_W-1:0];

  assign flush      = reset | redirect_valid;
  assign push_entry = '{pc: inflight_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc      <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      fpc      <= redirect_pc & 32'hFFFF_FFFC;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fpc;
        fpc         <= fpc + 32'd4;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .flush (flush),
    .push  (inflight),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .occ   (occ)
  );

  assign if_instr = if_valid ? head.instr : NOP_INSTR;
  assign if_pc    = if_valid ? head.pc : 32'd0;
  assign if_pc4   = if_valid ? head.pc + 32'd4 : 32'd0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, hand sequences and
// a request-time scoreboard for ordering, latency and credit.
module tb_instr_fetch_unit;
  import rv_fetch_pkg::*;

  localparam int          AW     = 9;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic [31:0]   if_pc4;

  instr_fetch_unit #(.IMEM_ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {{(32-AW){1'b0}}, pc[AW-1:0]} + 32'h100;
  endfunction

  // Instruction memory: 1-cycle read latency, garbage when not requested.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    imem_rdata <= imem_req ? {{(32-AW){1'b0}}, imem_addr} + 32'h100 : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          due;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] m_fpc;

  // Scoreboard: entries pushed when a request is issued, visible two cycles later.
  always @(negedge clk) begin
    if (mon_en) begin
      int   size0;
      bit   pop_now;
      bit   exp_valid;
      logic exp_req;
      size0     = sb.size();
      exp_valid = (size0 != 0) && (sb[0].due <= cyc);
      check("sb_valid", 32'(if_valid), 32'(exp_valid));
      pop_now = if_valid && if_ready;
      if (if_valid && size0 != 0) begin
        check("sb_pc", if_pc, sb[0].pc);
        check("sb_instr", if_instr, sb[0].instr);
        check("sb_pc4", if_pc4, sb[0].pc + 32'd4);
      end else if (!if_valid) begin
        check("sb_idle_instr", if_instr, NOP_INSTR);
        check("sb_idle_pc", if_pc, 32'd0);
        check("sb_idle_pc4", if_pc4, 32'd0);
      end
      if (pop_now && size0 != 0) void'(sb.pop_front());
      exp_req = !reset && !redirect_valid && ((size0 - int'(pop_now)) < DEPTH);
      check("sb_req", 32'(imem_req), 32'(exp_req));
      if (reset) begin
        sb.delete();
        m_fpc = RST_PC;
      end else if (redirect_valid) begin
        sb.delete();
        m_fpc = redirect_pc & 32'hFFFF_FFFC;
      end else if (imem_req) begin
        check("sb_addr", 32'(imem_addr), 32'(m_fpc[AW-1:0]));
        sb.push_back('{pc: m_fpc, instr: mem_word(m_fpc), due: cyc + 2});
        m_fpc = m_fpc + 32'd4;
      end
    end
  end

  task automatic idle(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    reset = rst; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk); #1;
  endtask

  // One cycle: drive inputs, compare outputs at the falling edge.
  task automatic cyc_chk(input string tag, input logic rst, input logic rdy, input logic rv,
                         input logic [31:0] rpc, input logic req, input logic [AW-1:0] addr,
                         input logic valid, input logic [31:0] pc);
    reset = rst; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(negedge clk);
    check({tag, "_req"}, 32'(imem_req), 32'(req));
    if (req) check({tag, "_addr"}, 32'(imem_addr), 32'(addr));
    check({tag, "_valid"}, 32'(if_valid), 32'(valid));
    check({tag, "_pc"}, if_pc, valid ? pc : 32'd0);
    check({tag, "_instr"}, if_instr, valid ? mem_word(pc) : NOP_INSTR);
    check({tag, "_pc4"}, if_pc4, valid ? pc + 32'd4 : 32'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          rdy;
    logic          rv;
    logic [31:0]   rpc;
    logic          req;
    logic [AW-1:0] addr;
    logic          valid;
    logic [31:0]   pc;
  } vec_t;

  vec_t tbl [10];

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      cyc_chk($sformatf("vec%0d", i), 1'b0, tbl[i].rdy, tbl[i].rv, tbl[i].rpc,
              tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].pc);
  endtask

  initial begin
    // Reset release at C0, streaming, redirect to 0x40 in C5.
    tbl[0] = '{1'b1, 1'b0, 32'h0,  1'b1, 9'h000, 1'b0, 32'h00};
    tbl[1] = '{1'b1, 1'b0, 32'h0,  1'b1, 9'h004, 1'b0, 32'h00};
    tbl[2] = '{1'b1, 1'b0, 32'h0,  1'b1, 9'h008, 1'b1, 32'h00};
    tbl[3] = '{1'b1, 1'b0, 32'h0,  1'b1, 9'h00C, 1'b1, 32'h04};
    tbl[4] = '{1'b1, 1'b0, 32'h0,  1'b1, 9'h010, 1'b1, 32'h08};
    tbl[5] = '{1'b1, 1'b1, 32'h40, 1'b0, 9'h000, 1'b1, 32'h0C};
    tbl[6] = '{1'b1, 1'b0, 32'h0,  1'b1, 9'h040, 1'b0, 32'h00};
    tbl[7] = '{1'b1, 1'b0, 32'h0,  1'b1, 9'h044, 1'b0, 32'h00};
    tbl[8] = '{1'b1, 1'b0, 32'h0,  1'b1, 9'h048, 1'b1, 32'h40};
    tbl[9] = '{1'b1, 1'b0, 32'h0,  1'b1, 9'h04C, 1'b1, 32'h44};

    reset = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    idle(1'b1, 1'b1, 1'b0, 32'h0);
    run_table(0, 9);

    // Decode stalled for 6 cycles after reset.
    idle(1'b1, 1'b1, 1'b0, 32'h0);
    idle(1'b1, 1'b1, 1'b0, 32'h0);
    cyc_chk("stall_c0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 9'h000, 1'b0, 32'h0);
    cyc_chk("stall_c1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 9'h004, 1'b0, 32'h0);
    for (int i = 2; i < 6; i++)
      cyc_chk($sformatf("stall_c%0d", i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 9'h000, 1'b1, 32'h0);
    cyc_chk("stall_c6", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 9'h008, 1'b1, 32'h0);
    cyc_chk("stall_c7", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 9'h00C, 1'b1, 32'h4);
    cyc_chk("stall_c8", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 9'h010, 1'b1, 32'h8);
    idle(1'b0, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect with simultaneous pop and an in-flight return.
    cyc_chk("rd43_r0", 1'b0, 1'b1, 1'b1, 32'h43, 1'b0, 9'h000, 1'b1, 32'h10);
    cyc_chk("rd43_r1", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 9'h040, 1'b0, 32'h0);
    cyc_chk("rd43_r2", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 9'h044, 1'b0, 32'h0);
    cyc_chk("rd43_r3", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 9'h048, 1'b1, 32'h40);

    // Fill the FIFO, then reset mid-stream; restart must match the first run.
    cyc_chk("full_s1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 9'h000, 1'b1, 32'h44);
    cyc_chk("full_s2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 9'h000, 1'b1, 32'h44);
    idle(1'b1, 1'b0, 1'b0, 32'h0);
    cyc_chk("rst_mid", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 9'h000, 1'b0, 32'h0);
    run_table(0, 4);

    // Redirect to the top of the address space; PC wraps to 0.
    cyc_chk("wrap_r0", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 9'h000, 1'b1, 32'h0C);
    cyc_chk("wrap_r1", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 9'h1FC, 1'b0, 32'h0);
    cyc_chk("wrap_r2", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 9'h000, 1'b0, 32'h0);
    cyc_chk("wrap_r3", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 9'h004, 1'b1, 32'hFFFF_FFFC);
    cyc_chk("wrap_r4", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 9'h008, 1'b1, 32'h0);

    // Back-to-back redirects: the second target wins.
    cyc_chk("b2b_r0", 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 9'h000, 1'b1, 32'h4);
    cyc_chk("b2b_r1", 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 9'h000, 1'b0, 32'h0);
    cyc_chk("b2b_r2", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 9'h020, 1'b0, 32'h0);
    cyc_chk("b2b_r3", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 9'h024, 1'b0, 32'h0);
    cyc_chk("b2b_r4", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 9'h028, 1'b1, 32'h20);

    repeat (3) idle(1'b0, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
